// File: rtl/snake_segment_renderer.sv
// snake_segment_renderer
//   Plots the snake body into the 160x120 frame buffer, one XDIM x YDIM block
//   per segment, head first. The vacated tail block can optionally be erased
//   first. The vga_* and plot outputs drive the adapter directly.
//
// Ports
//   Clock, Resetn        system clock, asynchronous active-low reset
//   start                single-cycle render request
//   len                  valid segment count (clamped to MAX_LEN)
//   body_x / body_y      packed segment coordinates, slot 0 = head
//   tail_x / tail_y      vacated tail block
//   erase_en             erase the tail block before drawing
//   colour               body colour
//   busy, done           render in progress / one-cycle completion pulse
//   vga_x, vga_y         pixel coordinate
//   vga_colour, plot     pixel colour and write strobe
//
// state  | meaning
// IDLE   | waiting for start
// ERASE  | scanning the tail block with BG_COLOUR
// DRAW   | scanning body block 'seg' with the captured colour
// FINISH | done pulse; a new start is accepted here
module snake_segment_renderer #(
   parameter int MAX_LEN = 4,
   parameter int XDIM = 10,
   parameter int YDIM = 10,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 start,
   input  logic [2:0]           len,
   input  logic [8*MAX_LEN-1:0] body_x,
   input  logic [7*MAX_LEN-1:0] body_y,
   input  logic [7:0]           tail_x,
   input  logic [6:0]           tail_y,
   input  logic                 erase_en,
   input  logic [2:0]           colour,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           vga_x,
   output logic [6:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 plot
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

   localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);
   localparam logic [7:0] X_LAST = 8'(XDIM - 1);
   localparam logic [6:0] Y_LAST = 7'(YDIM - 1);

   state_t state, nxt_state;
   logic [7:0] seg, nxt_seg;
   logic [7:0] xc, nxt_xc;
   logic [6:0] yc, nxt_yc;

   logic [7:0]           cap_eff;
   logic [8*MAX_LEN-1:0] cap_bx;
   logic [7*MAX_LEN-1:0] cap_by;
   logic [7:0]           cap_tx;
   logic [6:0]           cap_ty;
   logic                 cap_erase;
   logic [2:0]           cap_colour;

   logic                 accept;
   logic [7:0]           len_w, eff_in;
   logic [7:0]           src_eff;
   logic [8*MAX_LEN-1:0] src_bx;
   logic [7*MAX_LEN-1:0] src_by;
   logic [7:0]           src_tx;
   logic [6:0]           src_ty;
   logic                 src_erase;
   logic [2:0]           src_colour;

   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [8:0] wide_x;
   logic [7:0] wide_y;
   logic       active;
   logic       pix_plot;
   logic [2:0] pix_colour;

   assign accept = start && ((state == IDLE) || (state == FINISH));
   assign len_w  = {5'b0, len};
   assign eff_in = (len_w > MAX_LEN_W) ? MAX_LEN_W : len_w;

   // Outputs are registered from the next-cycle pixel, so on an accepted
   // start the first pixel must come from the live inputs, not the captures.
   assign src_eff    = accept ? eff_in   : cap_eff;
   assign src_bx     = accept ? body_x   : cap_bx;
   assign src_by     = accept ? body_y   : cap_by;
   assign src_tx     = accept ? tail_x   : cap_tx;
   assign src_ty     = accept ? tail_y   : cap_ty;
   assign src_erase  = accept ? erase_en : cap_erase;
   assign src_colour = accept ? colour   : cap_colour;

   always_comb begin
      nxt_state = state;
      nxt_seg   = seg;
      nxt_xc    = xc;
      nxt_yc    = yc;
      if (accept) begin
         nxt_seg = 8'd0;
         nxt_xc  = 8'd0;
         nxt_yc  = 7'd0;
         if (src_erase)
            nxt_state = ERASE;
         else if (src_eff != 8'd0)
            nxt_state = DRAW;
         else
            nxt_state = FINISH;
      end else begin
         case (state)
            IDLE:   nxt_state = IDLE;
            FINISH: nxt_state = IDLE;
            ERASE, DRAW: begin
               if (xc != X_LAST) begin
                  nxt_xc = xc + 8'd1;
               end else begin
                  nxt_xc = 8'd0;
                  if (yc != Y_LAST) begin
                     nxt_yc = yc + 7'd1;
                  end else begin
                     nxt_yc = 7'd0;
                     if (state == ERASE) begin
                        nxt_seg   = 8'd0;
                        nxt_state = (cap_eff == 8'd0) ? FINISH : DRAW;
                     end else if (seg == cap_eff - 8'd1) begin
                        nxt_state = FINISH;
                     end else begin
                        nxt_seg = seg + 8'd1;
                     end
                  end
               end
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   always_comb begin
      sel_x = src_tx;
      sel_y = src_ty;
      if (nxt_state == DRAW) begin
         sel_x = 8'd0;
         sel_y = 7'd0;
         for (int i = 0; i < MAX_LEN; i++) begin
            if (nxt_seg == 8'(i)) begin
               sel_x = src_bx[8*i +: 8];
               sel_y = src_by[7*i +: 7];
            end
         end
      end
   end

   // One bit wider than the outputs so off-screen pixels are detected
   // before truncation.
   assign wide_x     = {1'b0, sel_x} + {1'b0, nxt_xc};
   assign wide_y     = {1'b0, sel_y} + {1'b0, nxt_yc};
   assign active     = (nxt_state == ERASE) || (nxt_state == DRAW);
   assign pix_plot   = active && (wide_x < 9'd160) && (wide_y < 8'd120);
   assign pix_colour = (nxt_state == ERASE) ? BG_COLOUR :
                       (nxt_state == DRAW)  ? src_colour : 3'b000;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= IDLE;
         seg        <= 8'd0;
         xc         <= 8'd0;
         yc         <= 7'd0;
         cap_eff    <= 8'd0;
         cap_bx     <= '0;
         cap_by     <= '0;
         cap_tx     <= 8'd0;
         cap_ty     <= 7'd0;
         cap_erase  <= 1'b0;
         cap_colour <= 3'b000;
         busy       <= 1'b0;
         done       <= 1'b0;
         plot       <= 1'b0;
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'b000;
      end else begin
         state <= nxt_state;
         seg   <= nxt_seg;
         xc    <= nxt_xc;
         yc    <= nxt_yc;
         if (accept) begin
            cap_eff    <= eff_in;
            cap_bx     <= body_x;
            cap_by     <= body_y;
            cap_tx     <= tail_x;
            cap_ty     <= tail_y;
            cap_erase  <= erase_en;
            cap_colour <= colour;
         end
         busy       <= active;
         done       <= (nxt_state == FINISH);
         plot       <= pix_plot;
         vga_x      <= active ? wide_x[7:0] : 8'd0;
         vga_y      <= active ? wide_y[6:0] : 7'd0;
         vga_colour <= pix_colour;
      end
   end

endmodule
